// File: rtl/tick_pause_controller.sv
// tick_pause_controller
// Producer end of the tick/pause interface used by the LED mode processors.
//   - divides clk into a one-cycle tick strobe
//   - synchronises and debounces the raw pause push-button
//   - toggles the registered pause level on every accepted press
// tick is never high while pause is high: both are registered from the same
// pause_nxt value, and tick can only be set when pause_nxt is 0.
//
// Optional build macro: SPEED_SEL_EN
//   When defined, a 2-bit speed input is added. The effective divisor is
//   max(TICK_DIV >> speed, 1), which gives x1/x2/x4/x8 tick rates.
//   When undefined, the divisor is fixed at TICK_DIV.
//
// Debouncer states
//   state        | meaning
//   S_REL        | button released and stable
//   S_PRESS_WAIT | button seen pressed, counting stable cycles
//   S_PRS        | press accepted, button held
//   S_REL_WAIT   | button seen released, counting stable cycles

module tick_pause_controller #(
  parameter int TICK_DIV   = 25000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
`ifdef SPEED_SEL_EN
  input  logic [1:0] speed,
`endif
  output logic       tick,
  output logic       pause,
  output logic       btn_pulse
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] S_REL        = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT = 2'd1;
  localparam logic [1:0] S_PRS        = 2'd2;
  localparam logic [1:0] S_REL_WAIT   = 2'd3;

  logic [1:0]    btn_sync;
  logic          btn_s;
  logic [1:0]    deb_state;
  logic [1:0]    deb_state_nxt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_nxt;
  logic          press_acc;
  logic          pause_nxt;
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_last;

  // Two-stage synchroniser for the asynchronous button pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], btn_pause};
    end
  end

  assign btn_s = btn_sync[1];

  // Debouncer next-state logic; a press is accepted only after DEB_CYCLES
  // consecutive pressed samples, and a release never produces a pulse
  always_comb begin
    deb_state_nxt = deb_state;
    deb_cnt_nxt   = deb_cnt;
    press_acc     = 1'b0;
    case (deb_state)
      S_REL: begin
        if (btn_s) begin
          deb_state_nxt = S_PRESS_WAIT;
          deb_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!btn_s) begin
          deb_state_nxt = S_REL;
          deb_cnt_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_state_nxt = S_PRS;
          deb_cnt_nxt   = '0;
          press_acc     = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      S_PRS: begin
        if (!btn_s) begin
          deb_state_nxt = S_REL_WAIT;
          deb_cnt_nxt   = '0;
        end
      end
      S_REL_WAIT: begin
        if (btn_s) begin
          deb_state_nxt = S_PRS;
          deb_cnt_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_state_nxt = S_REL;
          deb_cnt_nxt   = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + DW'(1);
        end
      end
      default: begin
        deb_state_nxt = S_REL;
        deb_cnt_nxt   = '0;
      end
    endcase
  end

  // Debouncer state and stable-cycle counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_state <= S_REL;
      deb_cnt   <= '0;
    end else begin
      deb_state <= deb_state_nxt;
      deb_cnt   <= deb_cnt_nxt;
    end
  end

  // Value pause takes at this edge; the divider keys off it so a press
  // landing on a wrap edge suppresses that tick instead of overlapping pause
  assign pause_nxt = pause ^ press_acc;

  // Pause toggle and one-cycle press strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pause     <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      pause     <= pause_nxt;
      btn_pulse <= press_acc;
    end
  end

`ifdef SPEED_SEL_EN
  logic [1:0]  speed_q;
  logic [1:0]  speed_s;
  logic [31:0] div_eff;

  // Two-stage synchroniser for the speed select input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= 2'b00;
      speed_s <= 2'b00;
    end else begin
      speed_q <= speed;
      speed_s <= speed_q;
    end
  end

  // Effective divisor for the selected rate, never below one cycle
  always_comb begin
    div_eff = 32'(TICK_DIV) >> speed_s;
    if (div_eff == 32'd0) begin
      div_eff = 32'd1;
    end
    div_last = CW'(div_eff - 32'd1);
  end
`else
  assign div_last = DIV_LAST;
`endif

  // Tick divider; freezes (does not restart) while paused. The >= compare
  // lets a count left beyond a shortened period wrap on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (pause_nxt) begin
      tick <= 1'b0;
    end else if (div_cnt >= div_last) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_pause_controller.sv
// Directed bench for tick_pause_controller with TICK_DIV=4, DEB_CYCLES=3.
// Edge numbers count rising edges after reset release; outputs are sampled
// 1 time unit after each edge and inputs are changed at the same point.
// With SPEED_SEL_EN defined, a second instance (TICK_DIV=8) covers speed.

module tb_tick_pause_controller;

  logic clk = 1'b0;
  logic reset;
  logic btn_pause;
  logic tick;
  logic pause;
  logic btn_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef SPEED_SEL_EN
  logic [1:0] speed_main;
  logic [1:0] speed8;
  logic       btn8;
  logic       tick8;
  logic       pause8;
  logic       pulse8;

  tick_pause_controller #(.TICK_DIV(8), .DEB_CYCLES(3)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .btn_pause (btn8),
    .speed     (speed8),
    .tick      (tick8),
    .pause     (pause8),
    .btn_pulse (pulse8)
  );
`endif

  tick_pause_controller #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pause (btn_pause),
`ifdef SPEED_SEL_EN
    .speed     (speed_main),
`endif
    .tick      (tick),
    .pause     (pause),
    .btn_pulse (btn_pulse)
  );

  task automatic check(input string tag, input int e, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_r(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  // Scenario A: bounce, pause at count 2, resume, pause on a wrap edge, resume
  function automatic bit btn_a(input int e);
    return (e == 2) || (e == 4) || in_r(e, 6, 13) || in_r(e, 20, 27) ||
           in_r(e, 33, 39) || in_r(e, 44, 60);
  endfunction
  function automatic bit pulse_a(input int e);
    return e inside {11, 25, 38, 49};
  endfunction
  function automatic bit pause_a(input int e);
    return in_r(e, 11, 24) || in_r(e, 38, 48);
  endfunction
  function automatic bit tick_a(input int e);
    return e inside {4, 8, 26, 30, 34, 49, 53, 57};
  endfunction

  // Scenario B: button held 50 cycles, released, pressed again
  function automatic bit btn_b(input int e);
    return in_r(e, 1, 50) || in_r(e, 61, 75);
  endfunction
  function automatic bit pulse_b(input int e);
    return e inside {6, 66};
  endfunction
  function automatic bit pause_b(input int e);
    return in_r(e, 6, 65);
  endfunction
  function automatic bit tick_b(input int e);
    return e inside {4, 68, 72};
  endfunction

  task automatic reset_seq(input string tag);
    reset     = 1'b1;
    btn_pause = 1'b0;
    repeat (3) step();
    check({tag, "_rst_tick"},  0, tick,      1'b0);
    check({tag, "_rst_pause"}, 0, pause,     1'b0);
    check({tag, "_rst_pulse"}, 0, btn_pulse, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_pause = 1'b0;
`ifdef SPEED_SEL_EN
    speed_main = 2'b00;
    speed8     = 2'b11;
    btn8       = 1'b0;
`endif

    // Idle button: ticks at edges 4, 8, 12
    reset_seq("idle");
    for (int e = 1; e <= 12; e++) begin
      step();
      check("idle_tick",  e, tick,      (e % 4) == 0);
      check("idle_pause", e, pause,     1'b0);
      check("idle_pulse", e, btn_pulse, 1'b0);
    end

    // Scenario A
    reset_seq("a");
    for (int e = 1; e <= 60; e++) begin
      btn_pause = btn_a(e);
      step();
      check("a_tick",  e, tick,      tick_a(e));
      check("a_pause", e, pause,     pause_a(e));
      check("a_pulse", e, btn_pulse, pulse_a(e));
    end

    // Scenario B
    reset_seq("b");
    for (int e = 1; e <= 75; e++) begin
      btn_pause = btn_b(e);
      step();
      check("b_tick",  e, tick,      tick_b(e));
      check("b_pause", e, pause,     pause_b(e));
      check("b_pulse", e, btn_pulse, pulse_b(e));
    end

    // Scenario C: reset mid-hold while pulse and pause are high
    reset_seq("c");
    btn_pause = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("c_pulse", e, btn_pulse, e == 6);
      check("c_pause", e, pause,     e == 6);
      check("c_tick",  e, tick,      e == 4);
    end
    #3;
    reset = 1'b1;
    #1;
    check("c_async_pulse", 6, btn_pulse, 1'b0);
    check("c_async_pause", 6, pause,     1'b0);
    check("c_async_tick",  6, tick,      1'b0);
    repeat (2) step();
    check("c_inrst_pulse", 0, btn_pulse, 1'b0);
    check("c_inrst_pause", 0, pause,     1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("c2_pulse", e, btn_pulse, e == 6);
      check("c2_pause", e, pause,     e >= 6);
      check("c2_tick",  e, tick,      e == 4);
    end

`ifdef SPEED_SEL_EN
    // TICK_DIV=8: speed=3 gives a tick every cycle once synchronised,
    // then speed=1 gives a tick every 4 cycles
    speed8 = 2'b11;
    reset_seq("spd");
    for (int e = 1; e <= 10; e++) begin
      step();
      check("spd3_tick", e, tick8, e >= 3);
    end
    speed8 = 2'b01;
    for (int e = 11; e <= 24; e++) begin
      step();
      check("spd1_tick", e, tick8, e inside {11, 12, 16, 20, 24});
    end
    check("spd_pause", 24, pause8, 1'b0);
    check("spd_pulse", 24, pulse8, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
